// File: rtl/vedic_mult_arbiter.sv
// vedic_mult_arbiter: round-robin front end that shares a single combinational
// 8x8 Vedic multiplier between NUM_REQ requesters (2..4).
// Each request is a valid/ready channel. The single response is registered and
// tagged with the requester index.
// Optional feature macro: VEDIC_ARB_ZERO_BYPASS_EN
//   When defined, a request with a zero operand skips CALC.
//   Its zero response appears one cycle after the handshake.

// 2x2 Vedic block: vertical and crosswise partial products merged with half adders
module vedic_mult_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross0, cross1, carry1, top;

  assign cross0 = a[1] & b[0];
  assign cross1 = a[0] & b[1];
  assign carry1 = cross0 & cross1;
  assign top    = a[1] & b[1];
  assign p[0]   = a[0] & b[0];
  assign p[1]   = cross0 ^ cross1;
  assign p[2]   = top ^ carry1;
  assign p[3]   = top & carry1;
endmodule

// 4x4 Vedic block built from four 2x2 blocks
module vedic_mult_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  logic [5:0] mid;
  logic [3:0] hi;

  vedic_mult_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_mult_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_mult_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_mult_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  assign mid = {2'b00, q1} + {2'b00, q2} + {4'b0000, q0[3:2]};
  assign hi  = q3 + mid[5:2];
  assign p   = {hi, mid[1:0], q0[1:0]};
endmodule

// 8x8 Vedic multiplier built from four 4x4 blocks, full 16-bit unsigned product
module vedicmult_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;
  logic [9:0] mid;
  logic [7:0] hi;

  vedic_mult_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic_mult_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic_mult_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic_mult_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(q3));

  assign mid = {2'b00, q1} + {2'b00, q2} + {6'b000000, q0[7:4]};
  assign hi  = q3 + {2'b00, mid[9:4]};
  assign p   = {hi, mid[3:0], q0[3:0]};
endmodule

module vedic_mult_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*DATA_W-1:0]       rsp_data,
  output logic [1:0]                rsp_id
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t              state, next_state;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [1:0]          id, last_grant, grant, cand;
  logic                grant_found, accept, zero_op;
  logic [2*DATA_W-1:0] product;

  // The multiplier only ever sees the latched operands
  vedicmult_8bit u_mult (.a(op_a), .b(op_b), .p(product));

  // Round-robin search starting just after last_grant; descending loop so the nearest candidate wins
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = 2'((int'(last_grant) + i) % NUM_REQ);
      if (|(req_valid & (NUM_REQ'(1) << cand))) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  assign sel_a   = req_a[int'(grant)*DATA_W +: DATA_W];
  assign sel_b   = req_b[int'(grant)*DATA_W +: DATA_W];
  assign zero_op = (sel_a == '0) || (sel_b == '0);
  assign accept  = (state == IDLE) && grant_found;

  // State register with synchronous reset taking priority over any handshake
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic for the IDLE -> CALC -> RESP -> IDLE sequence
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef VEDIC_ARB_ZERO_BYPASS_EN
          next_state = zero_op ? RESP : CALC;
`else
          next_state = CALC;
`endif
        end
      end
      CALC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Only the granted requester sees ready, and only while idle
  always_comb begin
    req_ready = '0;
    if (accept) req_ready = NUM_REQ'(1) << grant;
  end

  // Operand latch, round-robin pointer and the registered response channel
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      id         <= '0;
      last_grant <= 2'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            id         <= grant;
            last_grant <= grant;
`ifdef VEDIC_ARB_ZERO_BYPASS_EN
            if (zero_op) begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_id    <= grant;
            end
`endif
          end
        end
        CALC: begin
          rsp_data  <= product;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
